// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle R-type issue controller for the RV32I
// regfile / ALU-buffer / ALU datapath.
// Optional macro EXEC_SEQ_OVERLAP_EN: accept the next instruction
// during WRITE when it does not read the register being written.
// Ports:
//   clock, reset (async, active low)
//   instr_valid, instr, instr_ready : instruction handshake
//   r1_addr, r2_addr, rw_addr, alu_op : decoded fields from the hold register
//   alubuf1_load, alubuf2_load, rf_write : datapath strobes
//   retire, illegal : one-cycle status pulses
//   busy, retire_count : activity and retired-instruction counter
module exec_sequencer #(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  output logic [4:0]       r1_addr,
  output logic [4:0]       r2_addr,
  output logic [4:0]       rw_addr,
  output logic [3:0]       alu_op,
  output logic             alubuf1_load,
  output logic             alubuf2_load,
  output logic             rf_write,
  output logic             retire,
  output logic             illegal,
  output logic             busy,
  output logic [CNT_W-1:0] retire_count
);

  if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
    $error("exec_sequencer: EXEC_CYCLES must be within 1..15");
  end

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WRITE
  } state_t;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [6:0] opcode_q;
  logic       accepted_q;
  logic       accept;
  logic       is_r;
  logic       unused_bits;

  assign accept = instr_valid && instr_ready;
  assign is_r = (instr[6:0] == OP_R);
  assign unused_bits = ^{instr[31], instr[29:25]};

`ifdef EXEC_SEQ_OVERLAP_EN
  // The incoming instruction would read rd before the write lands.
  logic hazard;
  assign hazard = (rw_addr != 5'd0) &&
                  ((instr[19:15] == rw_addr) ||
                   (instr[24:20] == rw_addr));
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && is_r) state_nxt = READ;
      end
      READ: state_nxt = EXEC;
      EXEC: begin
        if (cnt == 4'd0) state_nxt = WRITE;
      end
      WRITE: begin
`ifdef EXEC_SEQ_OVERLAP_EN
        state_nxt = (accept && is_r) ? READ : IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready  = 1'b0;
    alubuf1_load = 1'b0;
    alubuf2_load = 1'b0;
    rf_write     = 1'b0;
    retire       = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: instr_ready = 1'b1;
      READ: begin
        alubuf1_load = 1'b1;
        alubuf2_load = 1'b1;
      end
      WRITE: begin
        rf_write = (rw_addr != 5'd0);
        retire   = 1'b1;
`ifdef EXEC_SEQ_OVERLAP_EN
        instr_ready = !hazard;
`endif
      end
      default: ;
    endcase
  end

  // Held opcode plus an accept flag yield the illegal pulse in the
  // cycle after a non-R-type transfer.
  assign illegal = accepted_q && (opcode_q != OP_R);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r1_addr    <= '0;
      r2_addr    <= '0;
      rw_addr    <= '0;
      alu_op     <= '0;
      opcode_q   <= '0;
      accepted_q <= 1'b0;
    end else begin
      accepted_q <= accept;
      if (accept) begin
        r1_addr  <= instr[19:15];
        r2_addr  <= instr[24:20];
        rw_addr  <= instr[11:7];
        alu_op   <= {instr[30], instr[14:12]};
        opcode_q <= instr[6:0];
      end
    end
  end

  // Loaded during READ so EXEC lasts EXEC_CYCLES cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state == READ) begin
      cnt <= EXEC_LOAD;
    end else if (state == EXEC && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retire_count <= '0;
    end else if (state == WRITE) begin
      retire_count <= retire_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed plus random stimulus for exec_sequencer,
// checked against a timeline model of accepted instructions.
module tb_exec_sequencer;

  localparam int E  = 3;
  localparam int CW = 16;

  localparam logic [31:0] ADD3  = 32'h002081B3;
  localparam logic [31:0] ADD4  = 32'h00208233;
  localparam logic [31:0] ADD5  = 32'h001202B3;
  localparam logic [31:0] SUB0  = 32'h40208033;
  localparam logic [31:0] ADDI1 = 32'h00108093;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          instr_valid = 1'b0;
  logic [31:0]   instr = '0;
  logic          instr_ready;
  logic [4:0]    r1_addr;
  logic [4:0]    r2_addr;
  logic [4:0]    rw_addr;
  logic [3:0]    alu_op;
  logic          alubuf1_load;
  logic          alubuf2_load;
  logic          rf_write;
  logic          retire;
  logic          illegal;
  logic          busy;
  logic [CW-1:0] retire_count;

  exec_sequencer #(
    .EXEC_CYCLES(E),
    .CNT_W(CW)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_ready(instr_ready),
    .r1_addr(r1_addr),
    .r2_addr(r2_addr),
    .rw_addr(rw_addr),
    .alu_op(alu_op),
    .alubuf1_load(alubuf1_load),
    .alubuf2_load(alubuf2_load),
    .rf_write(rf_write),
    .retire(retire),
    .illegal(illegal),
    .busy(busy),
    .retire_count(retire_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: cycle index, accept cycle of the last R-type, illegal pulse
  // cycle, last accepted fields, retired count.
  int            cyc = 0;
  int            acc = -1000;
  int            ill = -1000;
  logic [4:0]    m_rs1 = '0;
  logic [4:0]    m_rs2 = '0;
  logic [4:0]    m_rd  = '0;
  logic [3:0]    m_op  = '0;
  logic [CW-1:0] m_cnt = '0;
  bit            accepted;

  logic       o_rf, o_ill, o_ret, o_l1, o_busy;
  logic [4:0] o_rw;
  logic [3:0] o_op;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit inf, wr, rd_ph, rdy;
    @(negedge clock);
    inf   = (cyc >= acc + 1) && (cyc <= acc + 2 + E);
    rd_ph = (cyc == acc + 1);
    wr    = (cyc == acc + 2 + E);
    rdy   = !inf;
`ifdef EXEC_SEQ_OVERLAP_EN
    if (wr && !(m_rd != 0 &&
        (instr[19:15] == m_rd || instr[24:20] == m_rd)))
      rdy = 1'b1;
`endif
    chk("busy", busy, inf);
    chk("instr_ready", instr_ready, rdy);
    chk("alubuf1_load", alubuf1_load, rd_ph);
    chk("alubuf2_load", alubuf2_load, rd_ph);
    chk("rf_write", rf_write, wr && m_rd != 0);
    chk("retire", retire, wr);
    chk("illegal", illegal, cyc == ill);
    chk("r1_addr", r1_addr, m_rs1);
    chk("r2_addr", r2_addr, m_rs2);
    chk("rw_addr", rw_addr, m_rd);
    chk("alu_op", alu_op, m_op);
    chk("retire_count", retire_count, m_cnt);
    o_rf = rf_write; o_ill = illegal; o_ret = retire;
    o_l1 = alubuf1_load; o_busy = busy; o_rw = rw_addr; o_op = alu_op;
    @(posedge clock);
    accepted = instr_valid && rdy;
    if (wr) m_cnt = m_cnt + 1'b1;
    if (accepted) begin
      m_rs1 = instr[19:15];
      m_rs2 = instr[24:20];
      m_rd  = instr[11:7];
      m_op  = {instr[30], instr[14:12]};
      if (instr[6:0] == 7'b0110011) acc = cyc;
      else ill = cyc + 1;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rf_write", rf_write, 0);
    chk("rst_retire", retire, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_load1", alubuf1_load, 0);
    chk("rst_load2", alubuf2_load, 0);
    chk("rst_r1", r1_addr, 0);
    chk("rst_rw", rw_addr, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_count", retire_count, 0);
    acc = -1000; ill = -1000;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_op = '0; m_cnt = '0;
    repeat (n) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst_ready", instr_ready, 1);
  endtask

  task automatic issue(input logic [31:0] w, output int n);
    instr_valid = 1'b1;
    instr = w;
    n = 0;
    accepted = 0;
    while (!accepted && n < 50) begin
      cycle();
      n++;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $error("FAIL issue_timeout observed=%0d expected<50", n);
    end
    instr_valid = 1'b0;
  endtask

  task automatic run_to_write(output int k);
    k = 0;
    o_rf = 1'b0;
    while (!o_ret && k < 30) begin
      cycle();
      k++;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 3) != 0) w[6:0] = 7'b0110011;
    else if (w[6:0] == 7'b0110011) w[6:0] = 7'b0010011;
    return w;
  endfunction

  initial begin
    int n, n2, n3, k;
    bit seen;
    instr_valid = 1'b1;
    instr = ADD3;
    #1;
    do_reset(3);

    issue(ADD3, n);
    chk("add_accept_wait", n, 1);
    o_ret = 1'b0;
    run_to_write(k);
    chk("add_latency", k, 2 + E);
    chk("add_rf_write", o_rf, 1);
    chk("add_rw", o_rw, 3);
    cycle();
    chk("add_count", retire_count, 1);

    issue(SUB0, n);
    cycle();
    chk("sub_alu_op", o_op, 4'b1000);
    chk("sub_load", o_l1, 1);
    seen = 0;
    k = 0;
    o_ret = 1'b0;
    while (!o_ret && k < 30) begin
      cycle();
      k++;
      if (o_rf) seen = 1;
    end
    chk("sub_no_write", seen, 0);
    chk("sub_retire", o_ret, 1);
    cycle();
    chk("sub_count", retire_count, 2);

    issue(ADDI1, n);
    cycle();
    chk("addi_illegal", o_ill, 1);
    chk("addi_busy", o_busy, 0);
    chk("addi_load", o_l1, 0);
    cycle();
    chk("addi_pulse_once", o_ill, 0);
    chk("addi_count", retire_count, 2);

    issue(ADD3, n);
    cycle();
    cycle();
    do_reset(2);
    repeat (4) cycle();
    issue(ADD3, n);
    o_ret = 1'b0;
    run_to_write(k);
    chk("post_rst_latency", k, 2 + E);
    chk("post_rst_rw", o_rw, 3);
    cycle();
    chk("post_rst_count", retire_count, 1);

    issue(ADD3, n);
    issue(ADD4, n2);
`ifdef EXEC_SEQ_OVERLAP_EN
    chk("overlap_spacing", n2, 2 + E);
`else
    chk("overlap_spacing", n2, 3 + E);
`endif
    issue(ADD5, n3);
    chk("hazard_spacing", n3, 3 + E);
    repeat (E + 4) cycle();

    for (int i = 0; i < 400; i++) begin
      instr_valid = ($urandom_range(0, 3) != 0);
      instr = rand_instr();
      if (i == 200) do_reset(1);
      cycle();
    end
    instr_valid = 1'b0;
    repeat (E + 6) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
